captura_lectura_rtc: RTL and testbench

Read sequencer and capture block for the RTC multiplexed address/data bus. On a start pulse from the main FSM it runs one multiplexed read cycle per time/date register: it drives the register address on `bus_out_leer`, releases the bus, samples `bus_in` and loads the value into a shadow register. When the sequence ends, all shadow values move to the output registers in the same clock cycle and `listo` pulses. It is the receiving side of the bus; the output-bus selector chooses `bus_out_leer` while `enable_leer` is high.

---
 rtl/captura_lectura_rtc.sv | 152 +++++++++++++++
 tb/tb_captura_lectura_rtc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/captura_lectura_rtc.sv
// Read sequencer for the RTC multiplexed AD bus: one read cycle per time/date register.
// Define LEER_TIMER_EN to append three timer reads (0x41..0x43) and ports timer0..timer2.
module captura_lectura_rtc #(
  parameter int unsigned T_FASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar_lectura,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out_leer,
  output logic       enable_leer,
  output logic       oe_bus,
  output logic       ad,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
`ifdef LEER_TIMER_EN
  output logic [7:0] timer0,
  output logic [7:0] timer1,
  output logic [7:0] timer2,
`endif
  output logic       listo
);

`ifdef LEER_TIMER_EN
  localparam int unsigned N = 9;
`else
  localparam int unsigned N = 6;
`endif
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(T_FASE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            fin;
  logic [7:0]      shadow [N];

  assign fin = (cnt == CNT_LAST);

  // Register address for a given read slot: RTC time block, then timer block.
  function automatic logic [7:0] addr_of(input logic [IW-1:0] i);
    if (i < IW'(6)) return 8'h21 + 8'(i);
    else            return 8'h41 + 8'(i - IW'(6));
  endfunction

  // Next-state / phase counter / register index.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (iniciar_lectura) begin
          state_n = S_ADDR;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      S_ADDR, S_GAP1, S_DATA: begin
        if (fin) begin
          cnt_n   = '0;
          state_n = (state == S_ADDR) ? S_GAP1 : (state == S_GAP1) ? S_DATA : S_GAP2;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_GAP2: begin
        if (fin) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ADDR;
            idx_n   = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      bus_out_leer <= 8'h00;
      enable_leer  <= 1'b0;
      oe_bus       <= 1'b0;
      ad           <= 1'b1;
      cs           <= 1'b1;
      rd           <= 1'b1;
      wr           <= 1'b1;
      listo        <= 1'b0;
      segundos     <= 8'h00;
      minutos      <= 8'h00;
      horas        <= 8'h00;
      dia          <= 8'h00;
      mes          <= 8'h00;
      anio         <= 8'h00;
`ifdef LEER_TIMER_EN
      timer0       <= 8'h00;
      timer1       <= 8'h00;
      timer2       <= 8'h00;
`endif
      for (int unsigned k = 0; k < N; k++) shadow[k] <= 8'h00;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      cs           <= !(state_n inside {S_ADDR, S_DATA});
      wr           <= (state_n != S_ADDR);
      ad           <= (state_n != S_ADDR);
      rd           <= (state_n != S_DATA);
      oe_bus       <= (state_n inside {S_ADDR, S_GAP1});
      enable_leer  <= (state_n != S_IDLE);
      bus_out_leer <= (state_n inside {S_ADDR, S_GAP1}) ? addr_of(idx_n) : 8'h00;
      listo        <= (state_n == S_DONE);
      // Capture on the edge that ends the rd-low window.
      if (state == S_DATA && fin) shadow[idx] <= bus_in;
      if (state_n == S_DONE) begin
        segundos <= shadow[0];
        minutos  <= shadow[1];
        horas    <= shadow[2];
        dia      <= shadow[3];
        mes      <= shadow[4];
        anio     <= shadow[5];
`ifdef LEER_TIMER_EN
        timer0   <= shadow[6];
        timer1   <= shadow[7];
        timer2   <= shadow[8];
`endif
      end
    end
  end

endmodule

// File: tb/tb_captura_lectura_rtc.sv
// Scoreboard bench for captura_lectura_rtc with a behavioural RTC register model.
module tb_captura_lectura_rtc;

  localparam int unsigned T = 10;
`ifdef LEER_TIMER_EN
  localparam int unsigned NR = 9;
`else
  localparam int unsigned NR = 6;
`endif
  localparam int unsigned SEQ = 4 * T * NR;
  localparam logic [7:0] ADDRS [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                       8'h41, 8'h42, 8'h43};

  logic clk = 1'b0;
  logic reset;
  logic iniciar_lectura;
  logic [7:0] bus_in;
  logic [7:0] bus_out_leer;
  logic enable_leer, oe_bus, ad, cs, rd, wr, listo;
  logic [7:0] segundos, minutos, horas, dia, mes, anio;
`ifdef LEER_TIMER_EN
  logic [7:0] timer0, timer1, timer2;
`endif

  captura_lectura_rtc #(.T_FASE(T)) dut (
    .clk(clk), .reset(reset), .iniciar_lectura(iniciar_lectura), .bus_in(bus_in),
    .bus_out_leer(bus_out_leer), .enable_leer(enable_leer), .oe_bus(oe_bus),
    .ad(ad), .cs(cs), .rd(rd), .wr(wr),
    .segundos(segundos), .minutos(minutos), .horas(horas), .dia(dia), .mes(mes), .anio(anio),
`ifdef LEER_TIMER_EN
    .timer0(timer0), .timer1(timer1), .timer2(timer2),
`endif
    .listo(listo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: latch address while ad is low, return memory contents while rd is low.
  logic [7:0] mem [256];
  logic [7:0] lat = 8'h00;
  logic [7:0] junk = 8'h5a;
  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (oe_bus && !ad) lat <= bus_out_leer;
  end
  always_comb bus_in = rd ? junk : mem[lat];

  logic [71:0] dut_dat;
  always_comb begin
    dut_dat = '0;
    dut_dat[47:0] = {anio, mes, dia, horas, minutos, segundos};
`ifdef LEER_TIMER_EN
    dut_dat[71:48] = {timer2, timer1, timer0};
`endif
  end

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues filled by the stimulus side.
  int unsigned exp_cyc_q [$];
  logic [71:0] exp_dat_q [$];
  logic [7:0]  addr_q    [$];
  logic [71:0] cur_out = '0;

  function automatic logic [71:0] model_data();
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < NR; i++) d[i*8 +: 8] = mem[ADDRS[i]];
    return d;
  endfunction

  task automatic push_exp(input int unsigned e0);
    exp_cyc_q.push_back(e0 + SEQ);
    exp_dat_q.push_back(model_data());
    for (int i = 0; i < NR; i++) addr_q.push_back(ADDRS[i]);
  endtask

  // Monitor: listo timing/data, output hold, address order, strobe protocol.
  int unsigned cs_run = 0, wr_run = 0, rd_run = 0;
  logic prev_wr = 1'b1;
  always @(negedge clk) begin
    if (!reset) begin
      cs_run = 0; wr_run = 0; rd_run = 0; prev_wr = 1'b1;
    end else begin
      if (listo) begin
        if (exp_cyc_q.size() == 0) chk("spurious_listo", 128'(listo), 128'(0));
        else begin
          chk("listo_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
          cur_out = exp_dat_q.pop_front();
        end
      end
      chk("data_outputs", 128'(dut_dat), 128'(cur_out));
      if (!oe_bus) chk("bus_out_idle", 128'(bus_out_leer), 128'(0));
      if (!rd) chk("rd_window_oe_ad", 128'({oe_bus, ad}), 128'(2'b01));
      if (!wr && prev_wr) begin
        if (addr_q.size() == 0) chk("unexpected_addr", 128'(wr), 128'(1));
        else chk("addr_seq", 128'(bus_out_leer), 128'(addr_q.pop_front()));
      end
      if (cs) begin if (cs_run != 0) chk("cs_width", 128'(cs_run), 128'(T)); cs_run = 0; end
      else cs_run++;
      if (wr) begin if (wr_run != 0) chk("wr_width", 128'(wr_run), 128'(T)); wr_run = 0; end
      else wr_run++;
      if (rd) begin if (rd_run != 0) chk("rd_width", 128'(rd_run), 128'(T)); rd_run = 0; end
      else rd_run++;
      prev_wr = wr;
    end
  end

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // Called at #1 after an edge; the pulse is sampled at the next edge (returned as e0).
  task automatic start_pulse(output int unsigned e0);
    iniciar_lectura = 1'b1;
    e0 = cyc + 1;
    push_exp(e0);
    @(posedge clk); #1;
    iniciar_lectura = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_strobes"}, 128'({ad, cs, rd, wr, oe_bus, enable_leer, listo}), 128'(7'b1111000));
    chk({name, "_bus"}, 128'(bus_out_leer), 128'(0));
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 9; i++) mem[ADDRS[i]] = 8'($urandom);
  endtask

  int unsigned e0, e1;

  initial begin
    reset = 1'b0;
    iniciar_lectura = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    repeat (3) @(posedge clk); #1;
    chk_idle("reset");
    chk("reset_data", 128'(dut_dat), 128'(0));
    reset = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk_idle("idle_no_start");

    // Directed read with stray start pulses that must be ignored.
    mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
    mem[8'h24] = 8'h07; mem[8'h25] = 8'h03; mem[8'h26] = 8'h16;
    mem[8'h41] = 8'h11; mem[8'h42] = 8'h22; mem[8'h43] = 8'h33;
    start_pulse(e0);
    wait_cyc(e0 + 49);  iniciar_lectura = 1'b1; @(posedge clk); #1; iniciar_lectura = 1'b0;
    wait_cyc(e0 + 238); iniciar_lectura = 1'b1; @(posedge clk); #1; iniciar_lectura = 1'b0;
    wait_cyc(e0 + SEQ + 3);
    chk("directed_drained", 128'(exp_cyc_q.size()), 128'(0));
    chk_idle("after_directed");

    // Request held high through DONE restarts two cycles after listo.
    rand_mem();
    iniciar_lectura = 1'b1;
    e0 = cyc + 1;
    push_exp(e0);
    push_exp(e0 + SEQ + 2);
    wait_cyc(e0 + SEQ + 2);
    iniciar_lectura = 1'b0;
    wait_cyc(e0 + 2 * SEQ + 4);
    chk("held_drained", 128'(exp_cyc_q.size()), 128'(0));

    // Asynchronous reset in the middle of the horas DATA phase.
    rand_mem();
    start_pulse(e0);
    wait_cyc(e0 + 105);
    #2 reset = 1'b0;
    exp_cyc_q.delete(); exp_dat_q.delete(); addr_q.delete();
    cur_out = '0;
    #1;
    chk_idle("midrun_reset");
    chk("midrun_reset_data", 128'(dut_dat), 128'(0));
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_idle("after_reset_release");
    rand_mem();
    start_pulse(e0);
    wait_cyc(e0 + SEQ + 2);
    chk("post_reset_drained", 128'(exp_cyc_q.size()), 128'(0));

    // Randomized back-to-back reads with random idle gaps and stray pulses.
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      start_pulse(e0);
      e1 = e0 + 1 + $urandom_range(1, SEQ - 3);
      wait_cyc(e1); iniciar_lectura = 1'b1; @(posedge clk); #1; iniciar_lectura = 1'b0;
      wait_cyc(e0 + SEQ + 1);
    end
    wait_cyc(cyc + 5);
    chk("final_drained", 128'(exp_cyc_q.size() + addr_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
